// File: rtl/card_pkg.sv
// Shared constants, FSM state type and card-word encoding for the card dealer.
package card_pkg;
  localparam int          DECK_SIZE = 52;
  localparam int          RANKS     = 13;
  localparam int          CARD_W    = 32;
  localparam int          ADDR_W    = 10;
  localparam int          IDX_W     = 6;
  localparam int          VALID_BIT = 31;
  localparam logic [5:0]  DECK_LAST = 6'd51;
  localparam logic [5:0]  DECK_FULL = 6'd52;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PICK,
    S_WRITE,
    S_FIN
  } state_e;

  // Suit is found by threshold compare; rank uses mod-16 subtraction on the low nibble.
  function automatic logic [CARD_W-1:0] card_word(input logic [IDX_W-1:0] idx);
    logic [1:0] suit;
    logic [3:0] rank;
    if (idx >= 6'd39) begin
      suit = 2'd3;
      rank = idx[3:0] - 4'd7 + 4'd1;
    end else if (idx >= 6'd26) begin
      suit = 2'd2;
      rank = idx[3:0] - 4'd10 + 4'd1;
    end else if (idx >= 6'd13) begin
      suit = 2'd1;
      rank = idx[3:0] - 4'd13 + 4'd1;
    end else begin
      suit = 2'd0;
      rank = idx[3:0] + 4'd1;
    end
    card_word            = '0;
    card_word[VALID_BIT] = 1'b1;
    card_word[5:4]       = suit;
    card_word[3:0]       = rank;
  endfunction
endpackage

// File: rtl/card_lfsr.sv
// 6-bit maximal-length Fibonacci LFSR (x^6 + x^5 + 1); nonzero seed keeps it off the all-zero state.
module card_lfsr #(
  parameter logic [5:0] SEED = 6'h2D
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic [5:0] value_o
);
  logic [5:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (en_i) lfsr_d = {lfsr_q[4:0], lfsr_q[5] ^ lfsr_q[4]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign value_o = lfsr_q;
endmodule

// File: rtl/card_dealer.sv
// Deals unused cards from a 52-card deck into a hand region of card memory,
// one registered write per card, tracking dealt cards until a new deck is requested.
module card_dealer
  import card_pkg::*;
#(
  parameter int         HAND_MAX  = 8,
  parameter int         RANDOM    = 1,
  parameter logic [5:0] LFSR_SEED = 6'h2D
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  hand_addr,
  input  logic [3:0]  num_cards,
  input  logic        new_deck,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_we,
  output logic [9:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic [5:0]  cards_left
);
  localparam logic [3:0] HAND_MAX_L = 4'(HAND_MAX);

  state_e      state_q, state_d;
  logic [51:0] used_q, used_d;
  logic [5:0]  left_q, left_d;
  logic [5:0]  cand_q, cand_d;
  logic [9:0]  base_q, base_d;
  logic [3:0]  num_q, num_d;
  logic [3:0]  k_q, k_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [9:0]  addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic [5:0]  lfsr_val;
  logic [5:0]  lfsr_cand;
  logic [5:0]  cand_next;
  logic [3:0]  k_inc;
  logic        req_bad;

  card_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i   (clock),
    .rst_i   (reset),
    .en_i    (1'b1),
    .value_o (lfsr_val)
  );

  // Fold the 1..63 LFSR range onto deck indices 0..51.
  assign lfsr_cand = (lfsr_val >= DECK_FULL) ? (lfsr_val - DECK_FULL) : lfsr_val;
  assign cand_next = (cand_q == DECK_LAST) ? 6'd0 : (cand_q + 6'd1);
  assign k_inc     = k_q + 4'd1;
  assign req_bad   = (num_cards == 4'd0) || (num_cards > HAND_MAX_L) ||
                     ({2'b00, num_cards} > left_q);

  always_comb begin
    state_d = state_q;
    used_d  = used_q;
    left_d  = left_q;
    cand_d  = cand_q;
    base_d  = base_q;
    num_d   = num_q;
    k_d     = k_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = hand_addr;
          num_d  = num_cards;
          k_d    = 4'd0;
          if (req_bad) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else begin
            state_d = S_PICK;
            if (RANDOM != 0) cand_d = lfsr_cand;
          end
        end else if (new_deck) begin
          used_d = '0;
          left_d = DECK_FULL;
          cand_d = 6'd0;
        end
      end
      S_PICK: begin
        cand_d = cand_next;
        if (!used_q[cand_q]) begin
          used_d[cand_q] = 1'b1;
          left_d         = left_q - 6'd1;
          wdata_d        = card_word(cand_q);
          addr_d         = base_q + {6'b0, k_q};
          we_d           = 1'b1;
          state_d        = S_WRITE;
        end
      end
      S_WRITE: begin
        k_d = k_inc;
        if (k_inc == num_q) begin
          done_d  = 1'b1;
          state_d = S_FIN;
        end else begin
          state_d = S_PICK;
          if (RANDOM != 0) cand_d = lfsr_cand;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      used_q  <= '0;
      left_q  <= DECK_FULL;
      cand_q  <= 6'd0;
      base_q  <= '0;
      num_q   <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      used_q  <= used_d;
      left_q  <= left_d;
      cand_q  <= cand_d;
      base_q  <= base_d;
      num_q   <= num_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign cards_left = left_q;
endmodule
